gpr_mp_sb: RTL

- Parametrised multi-port general-purpose register file with a per-register pending-write scoreboard.
- Successor to the single-read-pair, single-write GPR. Adds:
  - configurable read/write port counts, width and depth;
  - deterministic write-port priority and read bypass from all write ports;
  - counter-based busy tracking that the issue stage uses for hazard detection.
- Sits between decode/issue (reads, issue marks) and writeback (writes).

---
 rtl/gpr_mp_sb_if.sv | 33 +++
 rtl/gpr_mp_sb.sv | 93 +++++++++
 2 files changed

// File: rtl/gpr_mp_sb_if.sv
// Bus bundle for the multi-port GPR file: read ports, write/retire ports,
// issue marking, flush and the busy vector.
interface gpr_mp_sb_if #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned NRD  = 4,
  parameter int unsigned NWR  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR-1:0]    wr_retire;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_ready;
  logic              flush;
  logic [NREG-1:0]   busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_retire, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_retire, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_ready, busy_vec
  );
endinterface

// File: rtl/gpr_mp_sb.sv
// Multi-port register file with write bypass and a per-register
// pending-write counter scoreboard for issue-stage hazard checks.
module gpr_mp_sb #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned NRD      = 4,
  parameter int unsigned NWR      = 2,
  parameter int unsigned CNTW     = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic        clk,
  input logic        rst,
  gpr_mp_sb_if.slave bus
);
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned DECW = $clog2(NWR + 1);
  localparam int unsigned SW   = CNTW + DECW + 1;
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [DW-1:0]   mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] sat;
  logic            iss_acc;

  // Data array: later ports overwrite earlier ones on an address clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] &&
            !((ZERO_REG != 0) && (bus.wr_addr[j*AW +: AW] == AW'(0)))) begin
          mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*DW +: DW];
        end
      end
    end
  end

  // Read ports with bypass from every write port, highest index last.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    assign a = bus.rd_addr[i*AW +: AW];

    always_comb begin
      d = mem[a];
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == a)) d = bus.wr_data[j*DW +: DW];
      end
      if ((ZERO_REG != 0) && (a == AW'(0))) d = '0;
    end

    assign bus.rd_data[i*DW +: DW] = d;
    assign bus.rd_busy[i]          = busy[a];
  end

  assign bus.iss_ready = !sat[bus.iss_addr];
  assign iss_acc       = bus.iss_en && bus.iss_ready && !bus.flush;
  assign bus.busy_vec  = busy;

  // Pending-write counters: +1 on accepted issue, -1 per retiring write, floored at 0.
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      assign busy[r] = 1'b0;
      assign sat[r]  = 1'b0;
    end else begin : g_cnt
      logic [CNTW-1:0] cnt_q;
      logic [CNTW-1:0] cnt_d;
      logic [SW-1:0]   dec;
      logic [SW-1:0]   sum;

      always_comb begin
        dec = '0;
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && bus.wr_retire[j] && (bus.wr_addr[j*AW +: AW] == AW'(r))) begin
            dec = dec + SW'(1);
          end
        end
        sum   = SW'(cnt_q) + SW'(iss_acc && (bus.iss_addr == AW'(r)));
        cnt_d = (sum > dec) ? CNTW'(sum - dec) : '0;
      end

      always_ff @(posedge clk) begin
        if (rst || bus.flush) cnt_q <= '0;
        else                  cnt_q <= cnt_d;
      end

      assign busy[r] = (cnt_q != '0);
      assign sat[r]  = (cnt_q == CMAX);
    end
  end
endmodule
